// File: rtl/systolic_drain_pkg.sv
// Shared types and defaults for the systolic array output drain.
//   drain_state_t : drain FSM states
//   N/ACC_W/OUT_W : default array dimension and data widths
//   idx_w()       : width of a row-major index into an N x N grid (min 1)
package systolic_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drain_state_t;

    localparam int N     = 3;
    localparam int ACC_W = 20;
    localparam int OUT_W = 16;

    function automatic int idx_w(input int n);
        return (n * n > 1) ? $clog2(n * n) : 1;
    endfunction

endpackage

// File: rtl/systolic_drain_if.sv
// Drain stage bus: capture strobe + PE accumulators in, valid/ready element
// stream and status out.
//   master : the drain stage (consumes en_y/y_in/out_ready, drives the rest)
//   slave  : the surrounding fabric (counter, PE grid, downstream sink)
interface systolic_drain_if
    import systolic_pkg::*;
#(
    parameter int N     = systolic_pkg::N,
    parameter int ACC_W = systolic_pkg::ACC_W,
    parameter int OUT_W = systolic_pkg::OUT_W
);
    localparam int IDX_W = idx_w(N);

    logic                     en_y;
    logic [N*N*ACC_W-1:0]     y_in;
    logic                     out_valid;
    logic                     out_ready;
    logic [OUT_W-1:0]         out_data;
    logic [IDX_W-1:0]         out_idx;
    logic                     out_last;
    logic                     out_sat;
    logic                     busy;
    logic                     overrun;

    modport master (
        input  en_y, y_in, out_ready,
        output out_valid, out_data, out_idx, out_last, out_sat, busy, overrun
    );

    modport slave (
        output en_y, y_in, out_ready,
        input  out_valid, out_data, out_idx, out_last, out_sat, busy, overrun
    );

endinterface

// File: rtl/systolic_drain_sat_clamp.sv
// Signed saturating narrower, purely combinational.
//   in  : signed IN_W value
//   out : value clamped to the signed OUT_W range
//   sat : high when clamping changed the value
// OUT_W must not exceed IN_W; equal widths pass straight through.
module sat_clamp #(
    parameter int IN_W  = 20,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  in,
    output logic signed [OUT_W-1:0] out,
    output logic                    sat
);

    if (OUT_W == IN_W) begin : g_pass
        assign out = in;
        assign sat = 1'b0;
    end else begin : g_clamp
        // Range limits sign-extended to IN_W so the compare is a plain signed one.
        localparam logic signed [IN_W-1:0] MAXV = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
        localparam logic signed [IN_W-1:0] MINV = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

        always_comb begin
            out = in[OUT_W-1:0];
            sat = 1'b0;
            if (in > MAXV) begin
                out = MAXV[OUT_W-1:0];
                sat = 1'b1;
            end else if (in < MINV) begin
                out = MINV[OUT_W-1:0];
                sat = 1'b1;
            end
        end
    end

endmodule

// File: rtl/systolic_drain.sv
// Output drain for the systolic MAC array. en_y snapshots all N*N PE
// accumulators into a local buffer; the buffer is then streamed row-major,
// one element per valid/ready transfer, clamped to OUT_W. The PE grid is free
// to compute the next matrix while this one drains.
//   clk, reset : clock, async active-high reset
//   bus        : systolic_drain_if.master (en_y, y_in, out_* stream, busy, overrun)
module systolic_drain
    import systolic_pkg::*;
#(
    parameter int N     = systolic_pkg::N,
    parameter int ACC_W = systolic_pkg::ACC_W,
    parameter int OUT_W = systolic_pkg::OUT_W
) (
    input  logic             clk,
    input  logic             reset,
    systolic_drain_if.master bus
);

    localparam int                NN       = N * N;
    localparam int                IDX_W    = idx_w(N);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NN - 1);

    drain_state_t            r_state, w_next;
    logic [IDX_W-1:0]        r_idx;
    logic                    r_overrun;
    logic signed [ACC_W-1:0] r_buf [NN];

    logic                    w_xfer, w_at_last, w_cap;
    logic signed [ACC_W-1:0] w_cur;
    logic signed [OUT_W-1:0] w_clamped;
    logic                    w_sat;
    logic                    w_valid;

    assign w_valid   = (r_state == DRAIN);
    assign w_at_last = (r_idx == LAST_IDX);
    assign w_xfer    = w_valid && bus.out_ready;

    // Capture happens from IDLE, or on the final transfer so a new matrix
    // follows the old one with no idle cycle.
    always_comb begin
        w_next = r_state;
        w_cap  = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.en_y) begin
                    w_cap  = 1'b1;
                    w_next = DRAIN;
                end
            end
            DRAIN: begin
                if (w_xfer && w_at_last) begin
                    if (bus.en_y) w_cap  = 1'b1;
                    else          w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_cap)
                r_idx <= '0;
            else if (w_xfer)
                r_idx <= w_at_last ? '0 : r_idx + 1'b1;
            // A strobe that cannot be honoured is dropped and remembered.
            if (w_valid && bus.en_y && !w_cap)
                r_overrun <= 1'b1;
        end
    end

    // Data buffer carries no reset: contents are only observed after a capture.
    always_ff @(posedge clk) begin
        if (w_cap) begin
            for (int i = 0; i < NN; i++)
                r_buf[i] <= bus.y_in[i*ACC_W +: ACC_W];
        end
    end

    assign w_cur = r_buf[r_idx];

    sat_clamp #(
        .IN_W  (ACC_W),
        .OUT_W (OUT_W)
    ) u_clamp (
        .in  (w_cur),
        .out (w_clamped),
        .sat (w_sat)
    );

    // Element fields are forced to zero outside DRAIN.
    assign bus.out_valid = w_valid;
    assign bus.busy      = w_valid;
    assign bus.out_idx   = w_valid ? r_idx : '0;
    assign bus.out_last  = w_valid && w_at_last;
    assign bus.out_data  = w_valid ? w_clamped : '0;
    assign bus.out_sat   = w_valid && w_sat;
    assign bus.overrun   = r_overrun;

endmodule

// File: tb/tb_systolic_drain.sv
module tb_systolic_drain;

    localparam int N     = 3;
    localparam int ACC_W = 20;
    localparam int OUT_W = 16;
    localparam int NN    = N * N;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    systolic_drain_if #(.N(N), .ACC_W(ACC_W), .OUT_W(OUT_W)) bus ();

    systolic_drain #(.N(N), .ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic signed [ACC_W-1:0] v;   // accumulator value driven on y_in
        logic signed [OUT_W-1:0] d;   // expected out_data
        logic                    s;   // expected out_sat
    } vec_t;

    typedef struct {
        logic [OUT_W-1:0] d;
        logic [3:0]       idx;
        logic             last;
        logic             s;
    } exp_t;

    vec_t cur     [NN];
    vec_t sat_tbl [NN];
    exp_t q [$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Scoreboard: a beat is consumed whenever valid && ready before the edge.
    task automatic monitor();
        exp_t e;
        if (bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
                fail_now("unexpected_beat");
            end else begin
                e = q.pop_front();
                chk("beat", {bus.out_data, bus.out_idx, bus.out_last, bus.out_sat},
                            {e.d, e.idx, e.last, e.s});
            end
        end
    endtask

    task automatic tick();
        #1;
        monitor();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_seq(input int base);
        for (int i = 0; i < NN; i++) begin
            cur[i].v = ACC_W'(base + i);
            cur[i].d = OUT_W'(base + i);
            cur[i].s = 1'b0;
        end
    endtask

    task automatic load_cur(input bit push);
        exp_t e;
        for (int i = 0; i < NN; i++) begin
            bus.y_in[i*ACC_W +: ACC_W] = cur[i].v;
            if (push) begin
                e.d    = cur[i].d;
                e.idx  = 4'(i);
                e.last = (i == NN - 1);
                e.s    = cur[i].s;
                q.push_back(e);
            end
        end
    endtask

    task automatic capture();
        bus.en_y = 1'b1;
        tick();
        bus.en_y = 1'b0;
    endtask

    task automatic drain(input int keep);
        int b = 0;
        while (q.size() > keep && b < 100) begin
            tick();
            b++;
        end
        if (b >= 100) fail_now("drain_timeout");
    endtask

    task automatic chk_idle(input string name, input logic ovr);
        chk(name, {bus.out_valid, bus.busy, bus.overrun, bus.out_last, bus.out_sat,
                   bus.out_idx, bus.out_data},
                  {1'b0, 1'b0, ovr, 1'b0, 1'b0, 4'd0, 16'd0});
    endtask

    initial begin
        // Saturation table: boundary values around the 16-bit range.
        sat_tbl[0] = '{v:  20'sd1,      d:  16'sd1,     s: 1'b0};
        sat_tbl[1] = '{v:  20'sd32767,  d:  16'sd32767, s: 1'b0};
        sat_tbl[2] = '{v:  20'sd40000,  d:  16'sd32767, s: 1'b1};
        sat_tbl[3] = '{v:  20'sd32768,  d:  16'sd32767, s: 1'b1};
        sat_tbl[4] = '{v: -20'sd32768,  d: -16'sd32768, s: 1'b0};
        sat_tbl[5] = '{v: -20'sd40000,  d: -16'sd32768, s: 1'b1};
        sat_tbl[6] = '{v: -20'sd32769,  d: -16'sd32768, s: 1'b1};
        sat_tbl[7] = '{v: -20'sd1,      d: -16'sd1,     s: 1'b0};
        sat_tbl[8] = '{v:  20'sd524287, d:  16'sd32767, s: 1'b1};

        bus.en_y      = 1'b0;
        bus.out_ready = 1'b0;
        bus.y_in      = '0;

        // Reset state
        repeat (2) @(negedge clk);
        #1 chk_idle("reset_state", 1'b0);
        reset = 1'b0;
        @(negedge clk);

        // 1: plain stream 1..9 with ready held high
        set_seq(1);
        load_cur(1'b1);
        bus.out_ready = 1'b1;
        capture();
        chk("latency_valid", {bus.out_valid, bus.busy}, 2'b11);
        drain(0);
        chk_idle("t1_end", 1'b0);

        // 2: saturation table
        for (int i = 0; i < NN; i++) cur[i] = sat_tbl[i];
        load_cur(1'b1);
        capture();
        drain(0);
        chk_idle("t2_end", 1'b0);

        // 3: stall at idx 3 for four cycles
        set_seq(1);
        load_cur(1'b1);
        capture();
        repeat (3) tick();
        bus.out_ready = 1'b0;
        repeat (4) begin
            tick();
            chk("stall_hold", {bus.out_valid, bus.out_idx, bus.out_data, bus.out_last, bus.out_sat},
                              {1'b1, 4'd3, 16'd4, 1'b0, 1'b0});
        end
        bus.out_ready = 1'b1;
        drain(0);
        chk_idle("t3_end", 1'b0);

        // 5: back-to-back recapture on the last transfer
        set_seq(1);
        load_cur(1'b1);
        capture();
        drain(1);
        set_seq(10);
        load_cur(1'b1);
        bus.en_y = 1'b1;
        tick();
        bus.en_y = 1'b0;
        chk("b2b_first", {bus.out_valid, bus.out_idx, bus.out_data}, {1'b1, 4'd0, 16'd10});
        drain(0);
        chk_idle("t5_end", 1'b0);

        // 4: en_y mid-stream is dropped and flagged
        set_seq(1);
        load_cur(1'b1);
        capture();
        repeat (4) tick();
        set_seq(100);
        load_cur(1'b0);
        bus.en_y = 1'b1;
        tick();
        bus.en_y = 1'b0;
        chk("overrun_set", bus.overrun, 1'b1);
        drain(0);
        chk_idle("t4_end", 1'b1);

        // 6: asynchronous reset mid-stream, then a fresh start
        set_seq(1);
        load_cur(1'b1);
        capture();
        repeat (5) tick();
        chk("pre_reset_idx", bus.out_idx, 4'd5);
        #2 reset = 1'b1;
        #1 chk_idle("async_reset", 1'b0);
        q.delete();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk_idle("post_reset", 1'b0);
        set_seq(20);
        load_cur(1'b1);
        capture();
        chk("restart_idx0", {bus.out_valid, bus.out_idx, bus.out_data}, {1'b1, 4'd0, 16'd20});
        drain(0);
        chk_idle("t6_end", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
